// File: rtl/uart_wb_bridge_pkg.sv
// Shared command/response codes and FSM encodings for the UART-to-Wishbone debug bridge.
package uart_wb_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP,
        ST_TX_WAIT
    } state_e;

    typedef enum logic [1:0] {
        RK_ACK,
        RK_NAK,
        RK_READ
    } resp_kind_e;

    // Byte idx of a big-endian word (idx 0 = most significant byte).
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_wb_bridge_wdt.sv
// Bus-timeout down-counter: loaded on entry to a bus cycle, expires after TIMEOUT_CYCLES
// cycles of the cycle being held open.
module uart_wb_bridge_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_start) begin
            cnt_d = CW'(TIMEOUT_CYCLES);
        end else if (i_run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count is TIMEOUT_CYCLES in the first bus cycle, so terminal count 1 marks the last one.
    assign o_expire = i_run && (cnt_q == CW'(1));

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone debug bridge: parses write/read command frames, runs one 32-bit bus cycle,
// returns ACK/NAK or read data. Optional bus timeout under UART_WB_BRIDGE_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for a command byte
// ADDR       | shifting in A3..A0
// DATA       | shifting in D3..D0 (write only)
// BUS        | cyc/stb/sel asserted, waiting for ack
// RESP       | loading the next response byte once the transmitter is free
// TX_WAIT    | waiting for the transmitter busy window to open and close
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_frame_err,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    input  logic        i_tx_busy,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,
    output logic        o_busy
);

    state_e      state_q, state_d;
    resp_kind_e  rkind_q, rkind_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        seen_busy_q, seen_busy_d;
    logic [7:0]  resp_byte;
    logic        bus_timeout;

    always_comb begin
        case (rkind_q)
            RK_ACK:  resp_byte = RSP_ACK;
            RK_READ: resp_byte = word_byte(rdata_q, cnt_q);
            default: resp_byte = RSP_NAK;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rkind_d     = rkind_q;
        is_wr_d     = is_wr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rdata_d     = rdata_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        seen_busy_d = seen_busy_q;

        case (state_q)
            ST_IDLE: begin
                if (!i_frame_err && i_rx_valid) begin
                    cnt_d = 2'd0;
                    if ((i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ)) begin
                        is_wr_d = (i_rx_data == CMD_WRITE);
                        state_d = ST_ADDR;
                    end else begin
                        rkind_d = RK_NAK;
                        last_d  = 2'd0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (i_frame_err) begin
                    state_d = ST_IDLE;
                end else if (i_rx_valid) begin
                    adr_d = {adr_q[23:0], i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = is_wr_q ? ST_DATA : ST_BUS;
                    end
                end
            end
            ST_DATA: begin
                if (i_frame_err) begin
                    state_d = ST_IDLE;
                end else if (i_rx_valid) begin
                    dat_d = {dat_q[23:0], i_rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (i_wb_ack) begin
                    if (!is_wr_q) begin
                        rdata_d = i_wb_dat;
                    end
                    rkind_d = is_wr_q ? RK_ACK : RK_READ;
                    last_d  = is_wr_q ? 2'd0 : 2'd3;
                    cnt_d   = 2'd0;
                    state_d = ST_RESP;
                end else if (bus_timeout) begin
                    rkind_d = RK_NAK;
                    last_d  = 2'd0;
                    cnt_d   = 2'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!i_tx_busy) begin
                    tx_data_d   = resp_byte;
                    tx_start_d  = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (i_tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if (cnt_q == last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ST_RESP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rkind_q     <= RK_NAK;
            is_wr_q     <= 1'b0;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            adr_q       <= '0;
            dat_q       <= '0;
            rdata_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rkind_q     <= rkind_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rdata_q     <= rdata_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            seen_busy_q <= seen_busy_d;
        end
    end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    uart_wb_bridge_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .i_start  ((state_q != ST_BUS) && (state_d == ST_BUS)),
        .i_run    (state_q == ST_BUS),
        .i_clear  (i_wb_ack),
        .o_expire (bus_timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign bus_timeout        = 1'b0;
`endif

    // Bus strobes come straight from the state so reset drops them without waiting for an edge.
    assign o_wb_cyc   = (state_q == ST_BUS);
    assign o_wb_stb   = o_wb_cyc;
    assign o_wb_sel   = o_wb_cyc ? 4'hF : 4'h0;
    assign o_wb_we    = o_wb_cyc & is_wr_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Self-checking bench for uart_wb_bridge: table-driven frames plus frame-error, timeout and
// reset-during-bus sequences, against a zero-wait slave and a 4-cycle-busy transmitter model.
module tb_uart_wb_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_wdat, wb_rdat;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        busy;

    uart_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_frame_err(frame_err),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat), .o_wb_sel(wb_sel),
        .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_mem(input logic [31:0] a);
        return (a == 32'h3000_0000) ? 32'h1234_5678 : (a ^ 32'hA5A5_A5A5);
    endfunction

    // Zero-wait slave with optional stall-forever mode
    logic        noack = 1'b0;
    int          ncyc = 0;
    int          cyc_hi = 0;
    logic        log_we;
    logic [31:0] log_adr, log_dat;
    logic [3:0]  log_sel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack  <= 1'b0;
            wb_rdat <= '0;
        end else begin
            wb_ack  <= wb_cyc && wb_stb && !wb_ack && !noack;
            wb_rdat <= slave_mem(wb_adr);
        end
    end

    always @(posedge clk) begin
        if (wb_cyc) cyc_hi <= cyc_hi + 1;
        if (wb_cyc && wb_ack) begin
            ncyc    <= ncyc + 1;
            log_we  <= wb_we;
            log_adr <= wb_adr;
            log_dat <= wb_wdat;
            log_sel <= wb_sel;
        end
    end

    // Transmitter: busy for 4 cycles after each start
    logic [7:0] txq[$];
    int         busy_left;
    int         start_busy_viol = 0;
    int         data_unstable = 0;
    logic [7:0] held;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_start) begin
            if (tx_busy) start_busy_viol <= start_busy_viol + 1;
            txq.push_back(tx_data);
            held      <= tx_data;
            busy_left <= 4;
            tx_busy   <= 1'b1;
        end else if (busy_left > 0) begin
            if (tx_data !== held) data_unstable <= data_unstable + 1;
            busy_left <= busy_left - 1;
            tx_busy   <= (busy_left > 1);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [71:0] bytes, input int n);
        logic [71:0] w;
        w = bytes;
        for (int i = 0; i < n; i++) send_byte(w[71-8*i -: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 1000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_resp(input string name, input int base, input int nexp,
                              input logic [31:0] exp);
        logic [31:0] e;
        e = exp;
        check({name, "_nresp"}, 32'(txq.size() - base), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (base + i < txq.size())
                check({name, "_resp_byte"}, {24'h0, txq[base+i]}, {24'h0, e[31-8*i -: 8]});
            else
                check({name, "_resp_missing"}, 32'd0, 32'd1);
        end
    endtask

    typedef struct {
        string       name;
        logic [71:0] rx;
        int          nrx;
        int          ncyc;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          nresp;
        logic [31:0] resp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int b_cyc, b_hi, b_tx, n;

        vecs[0] = '{"wr_user", {8'h57, 32'h3000_0004, 32'hDEAD_BEEF}, 9, 1, 1'b1,
                    32'h3000_0004, 32'hDEAD_BEEF, 1, {8'h06, 24'h0}};
        vecs[1] = '{"rd_user", {8'h52, 32'h3000_0000, 32'h0}, 5, 1, 1'b0,
                    32'h3000_0000, 32'h0, 4, 32'h1234_5678};
        vecs[2] = '{"bad_cmd", {8'hAA, 64'h0}, 1, 0, 1'b0, 32'h0, 32'h0, 1, {8'h15, 24'h0}};
        vecs[3] = '{"wr_after_bad", {8'h57, 32'h0000_0100, 32'h0000_0055}, 9, 1, 1'b1,
                    32'h0000_0100, 32'h0000_0055, 1, {8'h06, 24'h0}};
        vecs[4] = '{"rd_low", {8'h52, 32'h0000_0010, 32'h0}, 5, 1, 1'b0,
                    32'h0000_0010, 32'h0, 4, 32'hA5A5_A5B5};

        rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        frame_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc", {31'h0, wb_cyc}, 32'd0);
        check("rst_stb", {31'h0, wb_stb}, 32'd0);
        check("rst_we", {31'h0, wb_we}, 32'd0);
        check("rst_sel", {28'h0, wb_sel}, 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_dat", wb_wdat, 32'd0);
        check("rst_tx", {23'h0, tx_start, tx_data}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            b_cyc = ncyc;
            b_hi  = cyc_hi;
            b_tx  = txq.size();
            send_frame(vecs[v].rx, vecs[v].nrx);
            wait_idle(vecs[v].name);
            check({vecs[v].name, "_ncyc"}, 32'(ncyc - b_cyc), 32'(vecs[v].ncyc));
            check({vecs[v].name, "_cyc_len"}, 32'(cyc_hi - b_hi), 32'(2 * vecs[v].ncyc));
            if (vecs[v].ncyc > 0) begin
                check({vecs[v].name, "_we"}, {31'h0, log_we}, {31'h0, vecs[v].we});
                check({vecs[v].name, "_adr"}, log_adr, vecs[v].adr);
                check({vecs[v].name, "_sel"}, {28'h0, log_sel}, 32'hF);
                if (vecs[v].we) check({vecs[v].name, "_dat"}, log_dat, vecs[v].dat);
            end
            check_resp(vecs[v].name, b_tx, vecs[v].nresp, vecs[v].resp);
        end

        // Aborted write followed by a full read
        b_cyc = ncyc;
        b_tx  = txq.size();
        send_byte(8'h57);
        send_byte(8'h30);
        send_byte(8'h00);
        @(negedge clk);
        frame_err = 1'b1;
        @(negedge clk);
        frame_err = 1'b0;
        @(negedge clk);
        check("ferr_busy", {31'h0, busy}, 32'd0);
        send_frame({8'h52, 32'h3000_0000, 32'h0}, 5);
        wait_idle("ferr");
        check("ferr_ncyc", 32'(ncyc - b_cyc), 32'd1);
        check("ferr_we", {31'h0, log_we}, 32'd0);
        check("ferr_adr", log_adr, 32'h3000_0000);
        check_resp("ferr", b_tx, 4, 32'h1234_5678);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        b_cyc = ncyc;
        b_hi  = cyc_hi;
        b_tx  = txq.size();
        noack = 1'b1;
        send_frame({8'h52, 32'h3000_0008, 32'h0}, 5);
        wait_idle("tmo");
        noack = 1'b0;
        check("tmo_cyc_len", 32'(cyc_hi - b_hi), 32'(TO));
        check("tmo_ncyc", 32'(ncyc - b_cyc), 32'd0);
        check_resp("tmo", b_tx, 1, {8'h15, 24'h0});
        check("tmo_busy", {31'h0, busy}, 32'd0);
`endif

        // Reset while the bus cycle is stalled
        noack = 1'b1;
        send_frame({8'h52, 32'h3000_000C, 32'h0}, 5);
        n = 0;
        while (!wb_cyc && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstbus_cyc_seen", 32'(n < 50), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstbus_cyc", {31'h0, wb_cyc}, 32'd0);
        check("rstbus_stb", {31'h0, wb_stb}, 32'd0);
        check("rstbus_sel", {28'h0, wb_sel}, 32'd0);
        check("rstbus_busy", {31'h0, busy}, 32'd0);
        check("rstbus_adr", wb_adr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        noack = 1'b0;
        b_tx = txq.size();
        repeat (30) @(negedge clk);
        check("rstbus_no_tx", 32'(txq.size() - b_tx), 32'd0);
        check("rstbus_idle", {30'h0, wb_cyc, busy}, 32'd0);

        check("start_while_busy", 32'(start_busy_viol), 32'd0);
        check("tx_data_stable", 32'(data_unstable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

UART-to-Wishbone debug bridge: the bus initiator that complements the UART register-slave side of the design. It parses command frames arriving as bytes from the UART receiver core and issues single 32-bit Wishbone read/write cycles. It returns status and read data as bytes to the UART transmitter core. It lets a host PC poke any Wishbone-mapped register, including user-project space at 0x3000_0000, without firmware involvement.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for `i_wb_ack` before aborting. Only used with the timeout feature compiled in.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte; valid only while `i_rx_valid`=1.
- i_rx_valid  in  1  one-cycle pulse per received byte.
- i_frame_err  in  1  receiver framing error; one-cycle pulse.
- o_tx_data  out  8  byte to transmit; stable from `o_tx_start` until `i_tx_busy` falls.
- o_tx_start  out  1  one-cycle transmit request.
- i_tx_busy  in  1  transmitter shifting a byte.
- o_wb_cyc, o_wb_stb  out  1  Wishbone cycle/strobe; always driven equal.
- o_wb_we  out  1  1 = write.
- o_wb_adr  out  32  byte address.
- o_wb_dat  out  32  write data.
- o_wb_sel  out  4  fixed 4'hF while `o_wb_cyc`=1; 0 otherwise.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_dat  in  32  read data; sampled on `i_wb_ack`.
- o_busy  out  1  high in every state except IDLE.

## Operation
- Frame formats (all multi-byte fields MSB first):
  - write: 0x57, A3..A0, D3..D0. Response: 0x06.
  - read: 0x52, A3..A0. Response: D3..D0.
  - error response: 0x15 (NAK).
- FSM states:
  - IDLE
    - 0x57 or 0x52 -> ADDR; latch the direction.
    - any other byte -> RESP with a single NAK.
  - ADDR
    - shift four bytes into `o_wb_adr` using a 2-bit counter.
    - after the 4th byte: write -> DATA; read -> BUS.
  - DATA: shift four bytes into `o_wb_dat`; after the 4th byte -> BUS.
  - BUS
    - assert cyc/stb/sel until `i_wb_ack`.
    - on ack: capture `i_wb_dat` (read only); deassert the next cycle -> RESP.
  - RESP
    - load the next response byte and pulse `o_tx_start` when `i_tx_busy`=0 -> TX_WAIT.
  - TX_WAIT
    - wait for `i_tx_busy` to go high, then low.
    - more bytes remain -> RESP; otherwise -> IDLE.
- `i_frame_err` in IDLE/ADDR/DATA: discard the partial frame -> IDLE, no response. Ignored in BUS/RESP/TX_WAIT.
- `i_rx_valid` in BUS/RESP/TX_WAIT: byte dropped silently. The host must wait for the response.
- Reset mid-operation: all state cleared asynchronously.
  - A bus cycle in flight is abandoned, with cyc/stb low immediately.
  - No response is sent.
- Reset values: all outputs 0, including `o_wb_sel`.
- `o_wb_adr` and `o_wb_dat` hold their last values between frames.

## Timing
- The byte accepted on an `i_rx_valid` cycle is reflected in registers on the next edge.
- cyc/stb rise on the edge after the last address byte (read) or last data byte (write).
- Zero-wait-state slave (ack in the cycle after stb is seen): cyc/stb high exactly 2 cycles.
- First `o_tx_start` is no earlier than 1 cycle after cyc falls.
- Back-to-back response bytes:
  - gap set by the transmitter's busy window plus 1 cycle.
  - no `o_tx_start` ever issued while `i_tx_busy`=1.

## Configuration
- `UART_WB_BRIDGE_TIMEOUT_EN` defined:
  - BUS counts cycles from cyc rise.
  - At TIMEOUT_CYCLES without ack: drop cyc/stb next edge, no data captured, respond with NAK.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - no counter; BUS waits indefinitely for ack.
  - TIMEOUT_CYCLES is unused.

## Structure
- Package `uart_wb_bridge_pkg`:
  - command codes 0x57/0x52; response codes 0x06/0x15.
  - FSM state enum.
- Sub-module `uart_wb_bridge_wdt`:
  - the bus-timeout counter (start/clear/expire).
  - instantiated only under `UART_WB_BRIDGE_TIMEOUT_EN`.

## Test plan
- Write: send 57 30 00 00 04 DE AD BE EF.
  - one cycle with we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=F.
  - TX emits 06.
- Read: slave returns 0x1234_5678 at 0x3000_0000; send 52 30 00 00 00.
  - one cycle with we=0, sel=F.
  - TX emits 12 34 56 78, each start only when `i_tx_busy`=0.
- Bad command: send 0xAA.
  - TX emits 15; no Wishbone cycle.
  - A following valid write executes normally.
- Frame error:
  - send 57 30 00, pulse `i_frame_err`, then a full read frame.
  - only the read executes; no response for the aborted frame.
- Timeout (macro defined, TIMEOUT_CYCLES=16), slave never acks:
  - cyc held 16 cycles then dropped.
  - TX emits 15; FSM returns to IDLE.
- Reset asserted mid-BUS: cyc/stb/sel drop asynchronously; `o_busy`=0; no TX byte follows.
